serial_fifo_ctrl: RTL and testbench

Buffered UART register block between the device controller's COM decode and the async receiver/transmitter pair. Captures received bytes into an RX FIFO and drains a TX FIFO into the transmitter one byte at a time. Exposes a data register and a status/control register to the CPU bus. Raises a level interrupt to CPU interrupt line `comInt`.

---
 rtl/serial_fifo_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_serial_fifo_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_fifo_ctrl.sv
// serial_fifo_ctrl: buffered UART register block.
//   An RX FIFO captures bytes from the async receiver.
//   A TX FIFO is drained into the transmitter one byte at a time by a small FSM.
//   The CPU sees a data register (mode_i=0) and a status/control register (mode_i=1).
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   enable_i, readEnable_i, mode_i, dataSave_i, dataLoad_o
//                         CPU bus access; dataLoad_o is combinational
//   int_o                 registered level interrupt
//   rxdReady_i, rxdData_i receiver byte strobe and data
//   txdBusy_i, txdStart_o, txdData_o
//                         transmitter handshake; txdData_o is registered
module serial_fifo_ctrl #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable_i,
  input  logic        readEnable_i,
  input  logic        mode_i,
  input  logic [31:0] dataSave_i,
  output logic [31:0] dataLoad_o,
  output logic        int_o,
  input  logic        rxdReady_i,
  input  logic [7:0]  rxdData_i,
  input  logic        txdBusy_i,
  output logic        txdStart_o,
  output logic [7:0]  txdData_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_HOLD  = 2'd2
  } tx_state_e;

  tx_state_e             state_r, state_nxt_s;
  logic [7:0]            rx_mem_r [DEPTH];
  logic [7:0]            tx_mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] rx_wptr_r, rx_rptr_r, tx_wptr_r, tx_rptr_r;
  logic [CW-1:0]         rx_count_r, tx_count_r, rx_count_nxt_s, tx_count_nxt_s;
  logic                  rx_overrun_r, tx_overflow_r, rx_int_en_r, tx_int_en_r;
  logic                  data_rd_s, data_wr_s, stat_rd_s, ctrl_wr_s;
  logic                  rx_empty_s, rx_full_s, tx_empty_s, tx_full_s, tx_idle_s;
  logic                  rx_push_s, rx_pop_s, tx_push_s, tx_pop_s;
  logic                  rx_ovr_set_s, tx_ovf_set_s;
  logic [7:0]            rx_head_s, rx_cnt8_s, tx_cnt8_s;
  logic [31:0]           status_s;
  logic                  unused_data_s;

  assign data_rd_s  = enable_i &  readEnable_i & ~mode_i;
  assign data_wr_s  = enable_i & ~readEnable_i & ~mode_i;
  assign stat_rd_s  = enable_i &  readEnable_i &  mode_i;
  assign ctrl_wr_s  = enable_i & ~readEnable_i &  mode_i;

  assign rx_empty_s = (rx_count_r == {CW{1'b0}});
  assign rx_full_s  = (rx_count_r == CW'(DEPTH));
  assign tx_empty_s = (tx_count_r == {CW{1'b0}});
  assign tx_full_s  = (tx_count_r == CW'(DEPTH));
  assign tx_idle_s  = (state_r == ST_IDLE);

  // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
  assign rx_pop_s     = data_rd_s & ~rx_empty_s;
  assign rx_push_s    = rxdReady_i & (~rx_full_s | rx_pop_s);
  assign rx_ovr_set_s = rxdReady_i & rx_full_s & ~rx_pop_s;
  assign tx_push_s    = data_wr_s & (~tx_full_s | tx_pop_s);
  assign tx_ovf_set_s = data_wr_s & tx_full_s & ~tx_pop_s;

  assign rx_head_s     = rx_mem_r[rx_rptr_r];
  assign rx_cnt8_s     = 8'(rx_count_r);
  assign tx_cnt8_s     = 8'(tx_count_r);
  assign unused_data_s = ^dataSave_i[31:8];

  assign status_s = {6'h00, tx_int_en_r, rx_int_en_r, tx_cnt8_s, rx_cnt8_s, 3'h0,
                     tx_overflow_r, tx_empty_s & tx_idle_s, rx_overrun_r,
                     ~rx_empty_s, ~tx_full_s};

  // Next FIFO occupancy from push/pop pair.
  always_comb begin
    rx_count_nxt_s = rx_count_r;
    case ({rx_push_s, rx_pop_s})
      2'b10:   rx_count_nxt_s = rx_count_r + CW'(1);
      2'b01:   rx_count_nxt_s = rx_count_r - CW'(1);
      default: rx_count_nxt_s = rx_count_r;
    endcase
    tx_count_nxt_s = tx_count_r;
    case ({tx_push_s, tx_pop_s})
      2'b10:   tx_count_nxt_s = tx_count_r + CW'(1);
      2'b01:   tx_count_nxt_s = tx_count_r - CW'(1);
      default: tx_count_nxt_s = tx_count_r;
    endcase
  end

  // FIFO storage; contents need no reset since the counts guard every read.
  always_ff @(posedge clk) begin
    if (rx_push_s) rx_mem_r[rx_wptr_r] <= rxdData_i;
    if (tx_push_s) tx_mem_r[tx_wptr_r] <= dataSave_i[7:0];
  end

  // Pointers, counts, sticky flags, interrupt enables and the interrupt register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wptr_r     <= {DEPTH_LOG2{1'b0}};
      rx_rptr_r     <= {DEPTH_LOG2{1'b0}};
      tx_wptr_r     <= {DEPTH_LOG2{1'b0}};
      tx_rptr_r     <= {DEPTH_LOG2{1'b0}};
      rx_count_r    <= {CW{1'b0}};
      tx_count_r    <= {CW{1'b0}};
      rx_overrun_r  <= 1'b0;
      tx_overflow_r <= 1'b0;
      rx_int_en_r   <= 1'b1;
      tx_int_en_r   <= 1'b0;
      int_o         <= 1'b0;
    end else begin
      if (rx_push_s) rx_wptr_r <= rx_wptr_r + DEPTH_LOG2'(1);
      if (rx_pop_s)  rx_rptr_r <= rx_rptr_r + DEPTH_LOG2'(1);
      if (tx_push_s) tx_wptr_r <= tx_wptr_r + DEPTH_LOG2'(1);
      if (tx_pop_s)  tx_rptr_r <= tx_rptr_r + DEPTH_LOG2'(1);
      rx_count_r    <= rx_count_nxt_s;
      tx_count_r    <= tx_count_nxt_s;
      // A new error event in the same cycle as a status read keeps the flag set.
      rx_overrun_r  <= rx_ovr_set_s | (rx_overrun_r & ~stat_rd_s);
      tx_overflow_r <= tx_ovf_set_s | (tx_overflow_r & ~stat_rd_s);
      if (ctrl_wr_s) begin
        rx_int_en_r <= dataSave_i[0];
        tx_int_en_r <= dataSave_i[1];
      end
      int_o <= (rx_int_en_r & ~rx_empty_s) |
               (tx_int_en_r & tx_empty_s & tx_idle_s) |
               rx_overrun_r;
    end
  end

  // TX FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_nxt_s;
  end

  // TX FSM next state; HOLD spends one cycle blind to busy while the transmitter raises it.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (~tx_empty_s & ~txdBusy_i) state_nxt_s = ST_START;
        else                          state_nxt_s = ST_IDLE;
      end
      ST_START: state_nxt_s = ST_HOLD;
      ST_HOLD:  state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // TX FSM outputs: start pulse decoded from START, pop issued on leaving IDLE.
  always_comb begin
    txdStart_o = 1'b0;
    tx_pop_s   = 1'b0;
    case (state_r)
      ST_IDLE:  tx_pop_s   = ~tx_empty_s & ~txdBusy_i;
      ST_START: txdStart_o = 1'b1;
      default: begin
        txdStart_o = 1'b0;
        tx_pop_s   = 1'b0;
      end
    endcase
  end

  // Transmit byte register, loaded together with the TX pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        txdData_o <= 8'h00;
    else if (tx_pop_s) txdData_o <= tx_mem_r[tx_rptr_r];
  end

  // CPU read mux; an empty RX FIFO reads as zero.
  always_comb begin
    dataLoad_o = 32'h0000_0000;
    if (data_rd_s & ~rx_empty_s) dataLoad_o = {24'h00_0000, rx_head_s};
    else if (stat_rd_s)          dataLoad_o = status_s;
    else                         dataLoad_o = 32'h0000_0000;
  end

endmodule

// File: tb/tb_serial_fifo_ctrl.sv
// Testbench for serial_fifo_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a queue-based reference model.
module tb_serial_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable_i = 1'b0, readEnable_i = 1'b0, mode_i = 1'b0;
  logic [31:0] dataSave_i = 32'h0;
  logic [31:0] dataLoad_o;
  logic        int_o;
  logic        rxdReady_i = 1'b0;
  logic [7:0]  rxdData_i = 8'h00;
  logic        txdBusy_i = 1'b0;
  logic        txdStart_o;
  logic [7:0]  txdData_o;

  serial_fifo_ctrl #(.DEPTH_LOG2(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable_i), .readEnable_i(readEnable_i),
    .mode_i(mode_i), .dataSave_i(dataSave_i), .dataLoad_o(dataLoad_o), .int_o(int_o),
    .rxdReady_i(rxdReady_i), .rxdData_i(rxdData_i), .txdBusy_i(txdBusy_i),
    .txdStart_o(txdStart_o), .txdData_o(txdData_o)
  );

  always #20 clk = ~clk;

  localparam int DEPTH = 16;

  int err_cnt = 0;
  int chk_cnt = 0;

  // Reference model state.
  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  bit         m_rx_ovr, m_tx_ovf, m_rx_ie, m_tx_ie, m_int;
  logic [7:0] m_txd;
  int         m_cyc, m_last_pop, last_start, n_starts;
  bit         auto_busy;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, m_cyc);
    end
  endtask

  task automatic model_reset();
    rxq.delete();
    txq.delete();
    m_rx_ovr = 1'b0; m_tx_ovf = 1'b0;
    m_rx_ie = 1'b1;  m_tx_ie = 1'b0;
    m_int = 1'b0;    m_txd = 8'h00;
    m_last_pop = -1000;
    last_start = -1000;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    enable_i = 1'b0; readEnable_i = 1'b0; mode_i = 1'b0; dataSave_i = 32'h0;
    rxdReady_i = 1'b0; rxdData_i = 8'h00; txdBusy_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_int", {31'h0, int_o}, 32'h0);
    check_val("rst_start", {31'h0, txdStart_o}, 32'h0);
    check_val("rst_txd", {24'h0, txdData_o}, 32'h0);
    rst_n = 1'b1;
  endtask

  // One bus cycle: drive, check outputs against the model, then advance the model.
  task automatic cyc_step(input bit en, input bit rd, input bit md, input logic [31:0] wd,
                          input bit rxr, input logic [7:0] rxd, input bit busy);
    bit          idle, start_e, dr, dw, sr, cw, new_int, tx_pop, rx_pop, rx_full, tx_full;
    bit          ovr_set, ovf_set;
    logic [31:0] exp_load, st;
    enable_i = en; readEnable_i = rd; mode_i = md; dataSave_i = wd;
    rxdReady_i = rxr; rxdData_i = rxd;
    txdBusy_i = auto_busy ? (m_cyc >= last_start + 1 && m_cyc <= last_start + 10) : busy;
    #1;
    // TX timing rule: pop at end of cycle P -> START in P+1, HOLD in P+2, IDLE from P+3.
    idle    = (m_cyc >= m_last_pop + 3);
    start_e = (m_cyc == m_last_pop + 1);
    dr = en && rd && !md;  dw = en && !rd && !md;
    sr = en && rd && md;   cw = en && !rd && md;
    st = 32'h0;
    st[0]     = txq.size() < DEPTH;
    st[1]     = rxq.size() > 0;
    st[2]     = m_rx_ovr;
    st[3]     = (txq.size() == 0) && idle;
    st[4]     = m_tx_ovf;
    st[15:8]  = 8'(rxq.size());
    st[23:16] = 8'(txq.size());
    st[24]    = m_rx_ie;
    st[25]    = m_tx_ie;
    if (dr)      exp_load = (rxq.size() > 0) ? {24'h0, rxq[0]} : 32'h0;
    else if (sr) exp_load = st;
    else         exp_load = 32'h0;
    check_val("data_load", dataLoad_o, exp_load);
    check_val("int", {31'h0, int_o}, {31'h0, m_int});
    check_val("txd_start", {31'h0, txdStart_o}, {31'h0, start_e});
    check_val("txd_data", {24'h0, txdData_o}, {24'h0, m_txd});
    if (txdStart_o) n_starts++;
    if (start_e) last_start = m_cyc;

    new_int = (m_rx_ie && rxq.size() > 0) || (m_tx_ie && txq.size() == 0 && idle) || m_rx_ovr;
    tx_pop  = idle && txq.size() > 0 && !txdBusy_i;
    rx_pop  = dr && rxq.size() > 0;
    rx_full = rxq.size() == DEPTH;
    tx_full = txq.size() == DEPTH;
    ovr_set = 1'b0; ovf_set = 1'b0;
    if (rx_pop) void'(rxq.pop_front());
    if (rxr) begin
      if (!rx_full || rx_pop) rxq.push_back(rxd);
      else ovr_set = 1'b1;
    end
    if (tx_pop) begin
      m_txd = txq.pop_front();
      m_last_pop = m_cyc;
    end
    if (dw) begin
      if (!tx_full || tx_pop) txq.push_back(wd[7:0]);
      else ovf_set = 1'b1;
    end
    m_rx_ovr = ovr_set || (m_rx_ovr && !sr);
    m_tx_ovf = ovf_set || (m_tx_ovf && !sr);
    if (cw) begin
      m_rx_ie = wd[0];
      m_tx_ie = wd[1];
    end
    m_int = new_int;
    m_cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cyc_step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 8'h00, 1'b0);
  endtask
  task automatic rx_byte(input logic [7:0] b);
    cyc_step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, b, 1'b0);
  endtask
  task automatic data_rd();
    cyc_step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 8'h00, 1'b0);
  endtask
  task automatic stat_rd(input bit busy);
    cyc_step(1'b1, 1'b1, 1'b1, 32'h0, 1'b0, 8'h00, busy);
  endtask
  task automatic data_wr(input logic [7:0] b, input bit busy);
    cyc_step(1'b1, 1'b0, 1'b0, {24'h0, b}, 1'b0, 8'h00, busy);
  endtask

  initial begin
    m_cyc = 0;
    n_starts = 0;
    auto_busy = 1'b0;
    do_reset();
    stat_rd(1'b0);

    // RX basic.
    rx_byte(8'h41);
    rx_byte(8'h42);
    idle_n(2);
    data_rd(); data_rd(); data_rd();
    idle_n(3);

    // RX overrun: 17 pushes, two status reads, drain.
    for (int i = 0; i < 17; i++) rx_byte(8'(i));
    stat_rd(1'b0);
    stat_rd(1'b0);
    for (int i = 0; i < 17; i++) data_rd();
    idle_n(2);

    // TX drain with a transmitter that goes busy one cycle after start for 10 cycles.
    auto_busy = 1'b1;
    n_starts = 0;
    data_wr(8'h55, 1'b0); data_wr(8'hAA, 1'b0); data_wr(8'h0F, 1'b0);
    idle_n(50);
    check_val("tx_pulses", n_starts, 32'd3);
    auto_busy = 1'b0;

    // TX overflow and TX-empty interrupt.
    for (int i = 0; i < 17; i++) data_wr(8'(8'h80 + i), 1'b1);
    stat_rd(1'b1);
    cyc_step(1'b1, 1'b0, 1'b1, 32'h2, 1'b0, 8'h00, 1'b1);
    idle_n(60);

    // Simultaneous push and pop with RX full.
    cyc_step(1'b1, 1'b0, 1'b1, 32'h1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 16; i++) rx_byte(8'(8'h10 + i));
    cyc_step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 8'h99, 1'b0);
    stat_rd(1'b0);
    for (int i = 0; i < 17; i++) data_rd();
    idle_n(2);

    // Reset during the START cycle.
    data_wr(8'h77, 1'b0);
    idle_n(1);
    enable_i = 1'b0; rxdReady_i = 1'b0; txdBusy_i = 1'b0;
    #1;
    check_val("mid_start", {31'h0, txdStart_o}, {31'h0, (m_cyc == m_last_pop + 1)});
    rst_n = 1'b0;
    #1;
    check_val("async_drop", {31'h0, txdStart_o}, 32'h0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    stat_rd(1'b0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bit          en, rd, md, rxr, bsy;
      logic [31:0] wd;
      int          rx_pct;
      auto_busy = (i >= 1500);
      rx_pct = ((i / 300) % 2 == 0) ? 45 : 10;
      en  = ($urandom_range(0, 99) < 40);
      rd  = $urandom_range(0, 1) == 1;
      md  = ($urandom_range(0, 3) == 0);
      wd  = $urandom;
      rxr = ($urandom_range(0, 99) < rx_pct);
      bsy = ($urandom_range(0, 2) == 0);
      cyc_step(en, rd, md, wd, rxr, 8'($urandom), bsy);
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
